// File: rtl/pc_sequencer.sv
// Program-counter sequencer for a microcode ROM: increment, jump, relative branch,
// call/return through a small return-address stack, with sticky stack error flags.
module pc_sequencer #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0,
    parameter bit          WRAP        = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               clr_err,
    output logic [ADDR_W-1:0]                  addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               unf_err,
    output logic                               halted
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << IDX_W;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] RST_A    = ADDR_W'(RESET_ADDR);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OpInc  = 3'd0,
        OpJmp  = 3'd1,
        OpBrr  = 3'd2,
        OpCall = 3'd3,
        OpRet  = 3'd4,
        OpHold = 3'd5
    } op_e;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              halted_q, halted_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_set, unf_set;
    logic              push;
    logic              full, empty;

    logic [ADDR_W-1:0] stack_q [SLOTS];
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [ADDR_W-1:0] addr_inc;
    op_e               op_dec;

    assign op_dec   = op_e'(op);
    assign addr_inc = addr_q + ADDR_W'(1);
    assign full     = (sp_q == SP_FULL);
    assign empty    = (sp_q == '0);
    assign wr_idx   = IDX_W'(sp_q);
    assign rd_idx   = IDX_W'(sp_q - SP_W'(1));

    always_comb begin
        addr_d   = addr_q;
        sp_d     = sp_q;
        halted_d = halted_q;
        push     = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (en) begin
            case (op_dec)
                OpHold: ;
                OpJmp: begin
                    addr_d   = target;
                    halted_d = 1'b0;
                end
                // Same-width add is the sign-extended offset modulo 2^ADDR_W.
                OpBrr: begin
                    addr_d   = addr_q + target;
                    halted_d = 1'b0;
                end
                OpCall: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push     = 1'b1;
                        sp_d     = sp_q + SP_W'(1);
                        addr_d   = target;
                        halted_d = 1'b0;
                    end
                end
                OpRet: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        addr_d   = stack_q[rd_idx];
                        sp_d     = sp_q - SP_W'(1);
                        halted_d = 1'b0;
                    end
                end
                default: begin
                    if (!WRAP && (addr_q == ADDR_MAX)) begin
                        halted_d = 1'b1;
                    end else begin
                        addr_d = addr_inc;
                    end
                end
            endcase
        end
        // A new error on the same edge beats the clear.
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= RST_A;
            sp_q     <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Stack storage is not reset; slots at or above sp are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_idx] <= addr_inc;
        end
    end

    assign addr        = addr_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
    assign halted      = WRAP ? 1'b0 : halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model pushes expected state into a
// scoreboard per driven op; each scenario task pops and compares after the clock edge.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] op = 3'd0;
    logic [8:0] target = 9'd0;
    logic       clr_err = 1'b0;

    logic [8:0] addr, nw_addr;
    logic [2:0] sp, nw_sp;
    logic       stack_full, stack_empty, ovf_err, unf_err, halted;
    logic       nw_full, nw_empty, nw_ovf, nw_unf, nw_halted;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .clr_err(clr_err),
        .addr(addr), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err), .halted(halted)
    );

    pc_sequencer #(.WRAP(1'b0)) dut_nw (
        .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .clr_err(clr_err),
        .addr(nw_addr), .sp(nw_sp), .stack_full(nw_full), .stack_empty(nw_empty),
        .ovf_err(nw_ovf), .unf_err(nw_unf), .halted(nw_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] m_stack[$];
    logic [8:0] m_addr;
    logic       m_ovf, m_unf;
    int         total = 0;
    int         bad = 0;

    // Reference model for the default (WRAP=1, depth 4) instance; one clock per call.
    task automatic drive_op(input logic e, input logic [2:0] o, input logic [8:0] t,
                            input logic c);
        logic so, su;
        exp_t x;
        en = e; op = o; target = t; clr_err = c;
        so = 1'b0; su = 1'b0;
        if (e) begin
            case (o)
                3'd1: m_addr = t;
                3'd2: m_addr = m_addr + t;
                3'd3: begin
                    if (m_stack.size() == 4) so = 1'b1;
                    else begin
                        m_stack.push_back(m_addr + 9'd1);
                        m_addr = t;
                    end
                end
                3'd4: begin
                    if (m_stack.size() == 0) su = 1'b1;
                    else m_addr = m_stack.pop_back();
                end
                3'd5: ;
                default: m_addr = m_addr + 9'd1;
            endcase
        end
        m_ovf = so | (m_ovf & ~c);
        m_unf = su | (m_unf & ~c);
        x.addr = m_addr;
        x.sp   = 3'(m_stack.size());
        x.ovf  = m_ovf;
        x.unf  = m_unf;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr = 9'd0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        repeat (2) begin
            total++;
            if (addr !== 9'd0 || sp !== 3'd0) begin
                bad++;
                $display("FAIL reset_addr_sp: got addr=%0d sp=%0d want 0 0", addr, sp);
            end
            total++;
            if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
                bad++;
                $display("FAIL reset_empty_full: got %b%b want 10", stack_empty, stack_full);
            end
            total++;
            if (ovf_err !== 1'b0 || unf_err !== 1'b0 || halted !== 1'b0 ||
                nw_halted !== 1'b0 || nw_addr !== 9'd0) begin
                bad++;
                $display("FAIL reset_flags: got ovf=%b unf=%b halt=%b nwhalt=%b nwaddr=%0d want 0",
                         ovf_err, unf_err, halted, nw_halted, nw_addr);
            end
            repeat (2) @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    task automatic test_inc_wrap();
        exp_t x;
        for (int i = 0; i < 513; i++) begin
            drive_op(1'b1, 3'd0, 9'd0, 1'b0);
            x = sb.pop_front();
            total++;
            if (addr !== x.addr || halted !== 1'b0) begin
                bad++;
                $display("FAIL inc_wrap[%0d]: got addr=%0d halted=%b want %0d 0",
                         i, addr, halted, x.addr);
            end
        end
    endtask

    task automatic test_halt();
        logic [2:0] ops[6]  = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd5, 3'd1};
        logic [8:0] tgts[6] = '{9'd510, 9'd0, 9'd0, 9'd0, 9'd0, 9'd5};
        logic [8:0] ea[6]   = '{9'd510, 9'd511, 9'd511, 9'd511, 9'd511, 9'd5};
        logic       eh[6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t x;
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, ops[i], tgts[i], 1'b0);
            x = sb.pop_front();
            total++;
            if (nw_addr !== ea[i] || nw_halted !== eh[i]) begin
                bad++;
                $display("FAIL halt_sat[%0d]: got addr=%0d halted=%b want %0d %b",
                         i, nw_addr, nw_halted, ea[i], eh[i]);
            end
            total++;
            if (addr !== x.addr || halted !== 1'b0) begin
                bad++;
                $display("FAIL halt_wrapdut[%0d]: got addr=%0d halted=%b want %0d 0",
                         i, addr, halted, x.addr);
            end
        end
    endtask

    task automatic test_ops_brr();
        logic [2:0] ops[8]  = '{3'd6, 3'd7, 3'd5, 3'd0, 3'd1, 3'd2, 3'd1, 3'd2};
        logic [8:0] tgts[8] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd100, 9'h1F6, 9'd5, 9'h1F6};
        logic [8:0] ea[8]   = '{9'd6, 9'd7, 9'd7, 9'd8, 9'd100, 9'd90, 9'd5, 9'd507};
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            drive_op(1'b1, ops[i], tgts[i], 1'b0);
            x = sb.pop_front();
            total++;
            if (addr !== x.addr || addr !== ea[i]) begin
                bad++;
                $display("FAIL ops_brr[%0d]: got addr=%0d want %0d", i, addr, ea[i]);
            end
        end
    endtask

    task automatic test_stack();
        logic [2:0] ops[11]  = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        logic [8:0] tgts[11] = '{9'd10, 9'd50, 9'd60, 9'd70, 9'd80, 9'd90, 9'd0, 9'd0, 9'd0,
                                 9'd0, 9'd0};
        logic [8:0] ea[11]   = '{9'd10, 9'd50, 9'd60, 9'd70, 9'd80, 9'd80, 9'd71, 9'd61,
                                 9'd51, 9'd11, 9'd11};
        exp_t x;
        for (int i = 0; i < 11; i++) begin
            drive_op(1'b1, ops[i], tgts[i], 1'b0);
            x = sb.pop_front();
            total++;
            if (addr !== x.addr || addr !== ea[i] || sp !== x.sp) begin
                bad++;
                $display("FAIL stack[%0d]: got addr=%0d sp=%0d want %0d %0d",
                         i, addr, sp, ea[i], x.sp);
            end
            total++;
            if (stack_full !== (x.sp == 3'd4) || stack_empty !== (x.sp == 3'd0) ||
                ovf_err !== x.ovf || unf_err !== x.unf) begin
                bad++;
                $display("FAIL stack_flags[%0d]: got full=%b empty=%b ovf=%b unf=%b want sp=%0d ovf=%b unf=%b",
                         i, stack_full, stack_empty, ovf_err, unf_err, x.sp, x.ovf, x.unf);
            end
        end
    endtask

    task automatic test_errors();
        logic       ens[11]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1};
        logic [2:0] ops[11]  = '{3'd4, 3'd5, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
                                 3'd5, 3'd4};
        logic [8:0] tgts[11] = '{9'd0, 9'd0, 9'd200, 9'd20, 9'd21, 9'd99, 9'd22, 9'd23,
                                 9'd24, 9'd0, 9'd0};
        logic       clr[11]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b0};
        exp_t x;
        for (int i = 0; i < 11; i++) begin
            drive_op(ens[i], ops[i], tgts[i], clr[i]);
            x = sb.pop_front();
            total++;
            if (addr !== x.addr || sp !== x.sp || ovf_err !== x.ovf || unf_err !== x.unf) begin
                bad++;
                $display("FAIL errors[%0d]: got addr=%0d sp=%0d ovf=%b unf=%b want %0d %0d %b %b",
                         i, addr, sp, ovf_err, unf_err, x.addr, x.sp, x.ovf, x.unf);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        while (m_stack.size() != 0) begin
            drive_op(1'b1, 3'd4, 9'd0, 1'b0);
            void'(sb.pop_front());
        end
        drive_op(1'b1, 3'd4, 9'd0, 1'b0);
        drive_op(1'b1, 3'd3, 9'd100, 1'b0);
        drive_op(1'b1, 3'd3, 9'd300, 1'b0);
        void'(sb.pop_front());
        void'(sb.pop_front());
        x = sb.pop_front();
        total++;
        if (addr !== 9'd300 || sp !== 3'd2 || unf_err !== 1'b1 || x.addr !== 9'd300) begin
            bad++;
            $display("FAIL areset_setup: got addr=%0d sp=%0d unf=%b want 300 2 1",
                     addr, sp, unf_err);
        end
        en = 1'b1; op = 3'd3; target = 9'd77;
        #3 rst = 1'b0;
        #1;
        model_reset();
        total++;
        if (addr !== 9'd0 || sp !== 3'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0 ||
            stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            bad++;
            $display("FAIL areset_async: got addr=%0d sp=%0d ovf=%b unf=%b empty=%b full=%b",
                     addr, sp, ovf_err, unf_err, stack_empty, stack_full);
        end
        @(posedge clk);
        #1;
        total++;
        if (addr !== 9'd0 || sp !== 3'd0) begin
            bad++;
            $display("FAIL areset_held: got addr=%0d sp=%0d want 0 0", addr, sp);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(i == 3, 3'd0, 9'd0, 1'b0);
            x = sb.pop_front();
            total++;
            if (addr !== x.addr || sp !== 3'd0) begin
                bad++;
                $display("FAIL areset_release[%0d]: got addr=%0d want %0d", i, addr, x.addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_halt();
        test_ops_brr();
        test_stack();
        test_errors();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9: width of the ROM address.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4 (range 1..16): number of return-address stack entries.
REQ-003 The block SHALL have parameter RESET_ADDR, default 0: address loaded on reset.
REQ-004 The block SHALL have parameter WRAP, default 1: 1 = increment wraps max->0; 0 = increment saturates at max and halts.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port en, input, 1 bit: advance enable; 0 = all state held.
REQ-008 The block SHALL have port op, input, 3 bits: 0 INC, 1 JMP, 2 BRR (relative), 3 CALL, 4 RET, 5 HOLD; 6-7 SHALL act as INC.
REQ-009 The block SHALL have port target, input, ADDR_W bits: absolute address (JMP/CALL) or two's-complement offset (BRR).
REQ-010 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port addr, output, ADDR_W bits: registered current ROM address.
REQ-012 The block SHALL have port sp, output, clog2(STACK_DEPTH+1) bits: number of occupied stack entries.
REQ-013 The block SHALL have ports stack_full and stack_empty, output, 1 bit each: combinational decode of sp (sp==STACK_DEPTH, sp==0).
REQ-014 The block SHALL have ports ovf_err and unf_err, output, 1 bit each: sticky stack overflow and underflow flags.
REQ-015 The block SHALL have port halted, output, 1 bit: saturated-end state (WRAP=0 only; constant 0 when WRAP=1).

Function
REQ-016 Latency: addr SHALL update on the rising edge on which en=1 and the op is sampled; one-cycle latency, no pipelining.
REQ-017 en=0: addr, stack, sp, halted held; clr_err still acts.
REQ-018 INC: addr <= addr+1 modulo 2^ADDR_W when WRAP=1.
REQ-019 INC with WRAP=0: at addr=2^ADDR_W-1, addr holds and halted<=1; below max, normal +1.
REQ-020 HOLD: addr unchanged; no other state change.
REQ-021 JMP: addr <= target; halted <= 0.
REQ-022 BRR: addr <= (addr + target) modulo 2^ADDR_W, target sign-extended, no saturation regardless of WRAP; halted <= 0.
REQ-023 CALL, not full: stack[sp] <= (addr+1) mod 2^ADDR_W; sp <= sp+1; addr <= target; halted <= 0.
REQ-024 CALL when full: no push, addr held, sp unchanged, ovf_err <= 1.
REQ-025 RET, not empty: addr <= stack[sp-1]; sp <= sp-1; halted <= 0.
REQ-026 RET when empty: addr held, sp unchanged, unf_err <= 1.
REQ-027 While halted=1, INC and HOLD SHALL keep addr at max; only JMP/BRR/CALL(success)/RET(success) leave halted.
REQ-028 clr_err=1 SHALL clear both error flags; if the same edge sets an error, set wins.
REQ-029 Stack SHALL be LIFO; entries above sp are don't-care and never observable on addr.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force addr=RESET_ADDR, sp=0, ovf_err=0, unf_err=0, halted=0; stack contents need not be cleared.
REQ-031 Reset mid-operation (e.g. during CALL edge) SHALL win; first op after release is sampled on the first rising edge with rst=1.
REQ-032 Outputs after reset: stack_empty=1, stack_full=0.

Verification
REQ-033 Defaults, en=1, op=INC for 514 cycles from reset -> addr 0,1,...,511,0,1; halted stays 0.
REQ-034 WRAP=0, JMP 510 then INC x3 -> addr 510,511,511,511; halted=1 from the second INC; then JMP 5 -> addr=5, halted=0.
REQ-035 addr=100, BRR target=9'h1F6 (-10) -> addr=90; addr=5, BRR -10 -> addr=507.
REQ-036 From addr=10: CALL 50, CALL 60, CALL 70, CALL 80 -> sp=4, stack_full=1; CALL 90 -> addr stays 80, ovf_err=1; RET x4 -> addr 71,61,51,11, sp=0; RET -> addr held 11, unf_err=1.
REQ-037 ovf_err=1, clr_err=1 with no error that edge -> flag 0; clr_err=1 on same edge as failing RET -> unf_err=1.
REQ-038 Assert rst=0 asynchronously mid-cycle with addr=300, sp=2 -> addr=0, sp=0, flags 0 before next clk edge; en=0 cycles after release -> addr stays 0.
